// File: rtl/cnn_pkg.sv
// Shared constants and window tap indexing for the convolution front end.
package cnn_pkg;

  localparam int unsigned KERNEL     = 3;
  localparam int unsigned TAPS       = KERNEL * KERNEL;
  localparam int unsigned DATA_W_DEF = 8;

  // Flat tap position of window element (r,c); (0,0) is the oldest pixel.
  function automatic int unsigned tap_idx(input int unsigned r, input int unsigned c);
    return KERNEL * r + c;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of pixel storage; the registered read returns the old word on a same-address write.
module line_buffer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 32
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/conv_window_gen.sv
// Pops raster pixels from the FIFO, keeps two lines of history and presents 3x3 stride-1 windows.
module conv_window_gen
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned IMG_H  = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic                   i_fifo_empty,
  input  logic [DATA_W-1:0]      i_fifo_data,
  output logic                   o_fifo_read_en,
  output logic                   o_fifo_read_sel,
  output logic [TAPS*DATA_W-1:0] o_win_data,
  output logic                   o_win_valid,
  input  logic                   i_win_ready,
  output logic                   o_win_last
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  logic [1:0][DATA_W-1:0]                    r_skid;
  logic [1:0]                                r_skid_cnt;
  logic                                      r_inflight;
  logic [CW-1:0]                             r_col;
  logic [RW-1:0]                             r_row;
  logic [KERNEL-1:0][KERNEL-1:0][DATA_W-1:0] r_win;
  logic                                      r_win_valid;
  logic                                      r_win_last;

  logic [1:0][DATA_W-1:0] w_skid_d;
  logic [1:0]             w_cnt_d;
  logic                   w_read;
  logic                   w_avail;
  logic                   w_accept;
  logic [DATA_W-1:0]      w_pix;
  logic [CW-1:0]          w_col_nxt;
  logic [RW-1:0]          w_row_nxt;
  logic                   w_col_end;
  logic [CW-1:0]          w_rd_addr;
  logic [DATA_W-1:0]      w_lb0;
  logic [DATA_W-1:0]      w_lb1;

  assign w_read   = !i_rst && i_en && !i_fifo_empty
                    && ((r_skid_cnt + {1'b0, r_inflight}) < 2'd2);
  // The word arriving this cycle counts as present and may bypass the skid.
  assign w_avail  = (r_skid_cnt != 2'd0) || r_inflight;
  assign w_accept = w_avail && (!r_win_valid || i_win_ready);
  assign w_pix    = (r_skid_cnt != 2'd0) ? r_skid[0] : i_fifo_data;

  assign w_col_end = (r_col == CW'(IMG_W - 1));
  assign w_col_nxt = w_col_end ? '0 : r_col + 1'b1;
  assign w_row_nxt = (r_row == RW'(IMG_H - 1)) ? '0 : r_row + 1'b1;
  // Prefetch the column the next accepted pixel will land in.
  assign w_rd_addr = w_accept ? w_col_nxt : r_col;

  always_comb begin
    w_skid_d = r_skid;
    w_cnt_d  = r_skid_cnt;
    if (w_accept && (r_skid_cnt != 2'd0)) begin
      w_skid_d[0] = r_skid[1];
      w_cnt_d     = r_skid_cnt - 2'd1;
    end
    if (r_inflight && !(w_accept && (r_skid_cnt == 2'd0))) begin
      w_skid_d[w_cnt_d[0]] = i_fifo_data;
      w_cnt_d              = w_cnt_d + 2'd1;
    end
  end

  line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W)
  ) u_lb0 (
    .i_clk   (i_clk),
    .i_we    (w_accept),
    .i_waddr (r_col),
    .i_wdata (w_pix),
    .i_raddr (w_rd_addr),
    .o_rdata (w_lb0)
  );

  line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W)
  ) u_lb1 (
    .i_clk   (i_clk),
    .i_we    (w_accept),
    .i_waddr (r_col),
    .i_wdata (w_lb0),
    .i_raddr (w_rd_addr),
    .o_rdata (w_lb1)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_skid      <= '0;
      r_skid_cnt  <= 2'd0;
      r_inflight  <= 1'b0;
      r_col       <= '0;
      r_row       <= '0;
      r_win       <= '0;
      r_win_valid <= 1'b0;
      r_win_last  <= 1'b0;
    end else begin
      r_inflight <= w_read;
      r_skid     <= w_skid_d;
      r_skid_cnt <= w_cnt_d;
      if (w_accept) begin
        for (int r = 0; r < KERNEL; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= w_lb1;
        r_win[1][2] <= w_lb0;
        r_win[2][2] <= w_pix;
        r_win_valid <= (r_row >= RW'(2)) && (r_col >= CW'(2));
        r_win_last  <= (r_row == RW'(IMG_H - 1)) && w_col_end;
        r_col       <= w_col_nxt;
        if (w_col_end) begin
          r_row <= w_row_nxt;
        end
      end else if (i_win_ready) begin
        r_win_valid <= 1'b0;
        r_win_last  <= 1'b0;
      end
    end
  end

  always_comb begin
    o_win_data = '0;
    for (int r = 0; r < KERNEL; r++) begin
      for (int c = 0; c < KERNEL; c++) begin
        o_win_data[DATA_W*tap_idx(r, c) +: DATA_W] = r_win[r][c];
      end
    end
  end

  assign o_fifo_read_en  = w_read;
  assign o_fifo_read_sel = w_read;
  assign o_win_valid     = r_win_valid;
  assign o_win_last      = r_win_last;

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomised scoreboard bench for conv_window_gen on a 4x4 image with a queue-backed FIFO model.
module tb_conv_window_gen;

  localparam int unsigned DW = 8;
  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;

  typedef struct {
    logic [9*DW-1:0] data;
    logic            last;
  } win_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            fifo_empty;
  logic [DW-1:0]   fifo_data;
  logic            read_en;
  logic            read_sel;
  logic [9*DW-1:0] win_data;
  logic            win_valid;
  logic            win_ready;
  logic            win_last;
  logic            force_empty;
  logic            thru_chk;

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned wins_seen = 0;

  logic [DW-1:0] src_q[$];
  win_t          exp_q[$];
  logic [DW-1:0] img[H][W];
  int unsigned   npix = 0;

  logic [9*DW-1:0] hold_data;
  logic            hold_last;
  bit              hold_pend = 1'b0;

  always #5 clk = ~clk;

  assign fifo_empty = force_empty || (src_q.size() == 0);

  conv_window_gen #(
    .DATA_W (DW),
    .IMG_W  (W),
    .IMG_H  (H)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_en            (en),
    .i_fifo_empty    (fifo_empty),
    .i_fifo_data     (fifo_data),
    .o_fifo_read_en  (read_en),
    .o_fifo_read_sel (read_sel),
    .o_win_data      (win_data),
    .o_win_valid     (win_valid),
    .i_win_ready     (win_ready),
    .o_win_last      (win_last)
  );

  task automatic check(input string name, input bit ok, input logic [9*DW-1:0] act,
                       input logic [9*DW-1:0] req);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  // Reference model: a frame image in raster order; each full 3x3 neighbourhood is one window.
  task automatic push_pixel(input logic [DW-1:0] p);
    int unsigned r, c;
    win_t w;
    src_q.push_back(p);
    r = (npix / W) % H;
    c = npix % W;
    img[r][c] = p;
    if (r >= 2 && c >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          w.data[DW*(3*i+j) +: DW] = img[r-2+i][c-2+j];
      w.last = (r == H - 1) && (c == W - 1);
      exp_q.push_back(w);
    end
    npix++;
  endtask

  task automatic push_frame(input int unsigned base, input bit rnd);
    for (int k = 0; k < int'(W * H); k++)
      push_pixel(rnd ? DW'($urandom) : DW'(base + k));
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk);
      if (exp_q.size() == 0 && src_q.size() == 0) break;
    end
    repeat (3) @(posedge clk);
    #1;
    check({"drain_", name}, exp_q.size() == 0 && src_q.size() == 0,
          72'(exp_q.size() + src_q.size()), 72'd0);
  endtask

  task automatic check_zero(input string name);
    @(negedge clk);
    check({name, "_read_en"}, read_en == 1'b0, 72'(read_en), 72'd0);
    check({name, "_read_sel"}, read_sel == 1'b0, 72'(read_sel), 72'd0);
    check({name, "_valid"}, win_valid == 1'b0, 72'(win_valid), 72'd0);
    check({name, "_last"}, win_last == 1'b0, 72'(win_last), 72'd0);
    check({name, "_data"}, win_data == '0, win_data, 72'd0);
  endtask

  always @(posedge clk) begin
    if (read_en && src_q.size() != 0) fifo_data <= src_q.pop_front();
  end

  // Monitor: pops the scoreboard on every handshake, independent of stimulus.
  always @(negedge clk) begin
    win_t e;
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (fifo_empty) check("no_read_when_empty", !read_en, 72'(read_en), 72'd0);
      check("read_sel_eq_en", read_sel == read_en, 72'(read_sel), 72'(read_en));
      if (thru_chk && src_q.size() != 0) check("read_every_cycle", read_en, 72'(read_en), 72'd1);
      if (hold_pend)
        check("bp_hold_stable", win_valid && win_data == hold_data && win_last == hold_last,
              win_data, hold_data);
      if (win_valid && win_ready) begin
        wins_seen++;
        check("window_expected", exp_q.size() != 0, win_data, 72'd0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("win_data", win_data == e.data, win_data, e.data);
          check("win_last", win_last == e.last, 72'(win_last), 72'(e.last));
        end
      end
      hold_pend = win_valid && !win_ready;
      hold_data = win_data;
      hold_last = win_last;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base;
    rst = 1'b1; en = 1'b0; force_empty = 1'b0; win_ready = 1'b0; thru_chk = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_zero("reset");

    // Plain frame at full rate.
    @(posedge clk); #1;
    en = 1'b1; win_ready = 1'b1; thru_chk = 1'b1;
    base = wins_seen;
    push_frame(0, 1'b0);
    wait_drain("s1");
    thru_chk = 1'b0;
    check("s1_windows", wins_seen - base == 4, 72'(wins_seen - base), 72'd4);

    // Backpressure hold of five cycles starting at the first window.
    push_frame(0, 1'b1);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (win_valid) break;
    end
    win_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid_held", win_valid, 72'(win_valid), 72'd1);
      if (k >= 2) check("bp_no_read", !read_en, 72'(read_en), 72'd0);
      @(posedge clk); #1;
    end
    win_ready = 1'b1;
    wait_drain("s3");

    // FIFO empty flag toggling every cycle.
    base = wins_seen;
    push_frame(0, 1'b0);
    for (int k = 0; k < 500; k++) begin
      @(posedge clk); #1;
      force_empty = ~force_empty;
      if (exp_q.size() == 0 && src_q.size() == 0) break;
    end
    force_empty = 1'b0;
    wait_drain("s4");
    check("s4_windows", wins_seen - base == 4, 72'(wins_seen - base), 72'd4);

    // Reset partway through a frame, then a fresh frame.
    for (int k = 0; k < 10; k++) push_pixel(DW'(k));
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; force_empty = 1'b1;
    check_zero("midrst");
    npix = 0;
    @(posedge clk); #1;
    force_empty = 1'b0;
    base = wins_seen;
    push_frame(0, 1'b0);
    wait_drain("s5");
    check("s5_windows", wins_seen - base == 4, 72'(wins_seen - base), 72'd4);

    // Back-to-back frames.
    base = wins_seen;
    push_frame(0, 1'b0);
    push_frame(100, 1'b0);
    wait_drain("s6");
    check("s6_windows", wins_seen - base == 8, 72'(wins_seen - base), 72'd8);

    // Random pixels and random en / ready / empty.
    for (int f = 0; f < 3; f++) push_frame(0, 1'b1);
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      win_ready   = ($urandom_range(3) != 0);
      en          = ($urandom_range(9) != 0);
      force_empty = ($urandom_range(3) == 0);
      if (exp_q.size() == 0 && src_q.size() == 0) break;
    end
    win_ready = 1'b1; en = 1'b1; force_empty = 1'b0;
    wait_drain("s7");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
